// File: rtl/mux_pkg.sv
// Shared definitions for the registered output crossbar mux (mux_reg_xbar).
// Holds default geometry, the error-counter width and the grant-decode helpers.
// Optional feature macro used by the top: MUX_ERR_CNT_EN (adds err_cnt output).
package mux_pkg;

  localparam int NPORT_DEF = 5;
  localparam int DATAW_DEF = 64;
  localparam int VCHW_DEF  = 2;
  localparam int ERR_CNT_W = 8;

  // Grant helpers work on a fixed-width grant vector so one function serves
  // every instance; callers zero-extend their sel and narrow the index back.
  localparam int MAX_NPORT = 32;
  localparam int MAX_IDXW  = $clog2(MAX_NPORT);

  // True when exactly one grant bit is set.
  function automatic logic is_onehot(input logic [MAX_NPORT-1:0] s);
    return (s != '0) && ((s & (s - MAX_NPORT'(1))) == '0);
  endfunction

  // Position of the set bit of a one-hot grant; 0 when the grant is empty.
  // Only meaningful when is_onehot() holds.
  function automatic logic [MAX_IDXW-1:0] onehot_to_idx(input logic [MAX_NPORT-1:0] s);
    logic [MAX_IDXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NPORT; i++) begin
      if (s[i]) idx = MAX_IDXW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// Two-entry valid/ready output buffer.
// Handshake: a word transfers on a port in every cycle where both valid and
// ready are high at the rising edge; in_ready depends only on the registered
// occupancy, so there is no combinational path from out_ready to in_ready.
// Outputs come straight from the head register.
module mux_skid_buf
  import mux_pkg::*;
#(
  parameter int W = DATAW_DEF + VCHW_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [1:0]   count_q;
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic         push;
  logic         pop;

  // Occupancy decode and transfer qualifiers.
  always_comb begin
    in_ready  = (count_q != 2'd2);
    out_valid = (count_q != 2'd0);
    out_data  = head_q;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // FIFO state: head is the visible entry, tail only holds data when full.
  // Empty entries keep their last contents; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            head_q  <= in_data;
            count_q <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= in_data;
          end else if (push) begin
            tail_q  <= in_data;
            count_q <= 2'd2;
          end else if (pop) begin
            count_q <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_q  <= tail_q;
            count_q <= 2'd1;
          end
        end
        default: count_q <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/mux_reg_xbar.sv
// Registered output-port crossbar mux: picks one of NPORT flit streams with a
// one-hot grant and buffers it in a 2-entry output queue toward the link.
// Multi-hot grants are rejected and reported one cycle later on sel_err.
// Optional feature macro: MUX_ERR_CNT_EN adds an 8-bit saturating err_cnt.
// NPORT is limited to 2..32 by the grant helpers in mux_pkg.
module mux_reg_xbar
  import mux_pkg::*;
#(
  parameter int NPORT = NPORT_DEF,
  parameter int DATAW = DATAW_DEF,
  parameter int VCHW  = VCHW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NPORT*DATAW-1:0] idata,
  input  logic [NPORT-1:0]       ivalid,
  input  logic [NPORT*VCHW-1:0]  ivch,
  input  logic [NPORT-1:0]       sel,
  output logic [NPORT-1:0]       iready,
  output logic [DATAW-1:0]       odata,
  output logic                   ovalid,
  output logic [VCHW-1:0]        ovch,
  input  logic                   oready,
`ifdef MUX_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0]   err_cnt,
`endif
  output logic                   sel_err
);

  localparam int IDXW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int W    = DATAW + VCHW;

  logic [MAX_NPORT-1:0] sel_ext;
  logic                 sel_onehot;
  logic                 sel_multi;
  logic [IDXW-1:0]      sel_idx;
  logic [DATAW-1:0]     mux_data;
  logic [VCHW-1:0]      mux_vch;
  logic                 mux_valid;
  logic                 buf_in_valid;
  logic                 buf_in_ready;
  logic [W-1:0]         buf_out;

  // Grant decode and data/VC/valid selection from the granted port.
  always_comb begin
    sel_ext    = MAX_NPORT'(sel);
    sel_onehot = is_onehot(sel_ext);
    sel_multi  = (sel != '0) && !sel_onehot;
    sel_idx    = IDXW'(onehot_to_idx(sel_ext));
    mux_data   = '0;
    mux_vch    = '0;
    mux_valid  = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (sel_idx == IDXW'(i)) begin
        mux_data  = idata[i*DATAW +: DATAW];
        mux_vch   = ivch[i*VCHW +: VCHW];
        mux_valid = ivalid[i];
      end
    end
  end

  // Accept is offered only to the granted port, only on a legal grant and
  // only while the buffer has room. Held low during reset.
  always_comb begin
    buf_in_valid = rst_n & sel_onehot & mux_valid;
    iready       = (rst_n && sel_onehot && buf_in_ready) ? sel : '0;
  end

  mux_skid_buf #(
    .W (W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({mux_vch, mux_data}),
    .in_valid  (buf_in_valid),
    .in_ready  (buf_in_ready),
    .out_data  (buf_out),
    .out_valid (ovalid),
    .out_ready (oready)
  );

  // VC id travels in the top bits of the same buffer entry as its data.
  always_comb begin
    odata = buf_out[DATAW-1:0];
    ovch  = buf_out[W-1:DATAW];
  end

  // One-cycle error pulse following any cycle with a multi-hot grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= sel_multi;
    end
  end

`ifdef MUX_ERR_CNT_EN
  // Saturating count of multi-hot grant cycles; cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (sel_multi && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule
